// File: rtl/time_core_updown_pkg.sv
// Shared encodings and BCD helpers for the HH:MM:SS up/down timekeeping core.
package time_core_updown_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HR   = 2'd2,
    FIELD_NONE = 2'd3
  } field_e;

  // LSB of each 8-bit {tens, ones} field inside load_val / alarm_val
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 8;
  localparam int HR_LSB  = 16;

  function automatic logic field_ok(input logic [7:0] f, input int max);
    int t, o;
    t = int'(f[7:4]);
    o = int'(f[3:0]);
    return (t <= 9) && (o <= 9) && (t <= max / 10) && (t * 10 + o <= max);
  endfunction

  function automatic logic time_ok(input logic [23:0] v, input int hr_max, input int sec_max);
    return field_ok(v[HR_LSB +: 8], hr_max) && field_ok(v[MIN_LSB +: 8], sec_max) &&
           field_ok(v[SEC_LSB +: 8], sec_max);
  endfunction

endpackage

// File: rtl/time_core_updown_bcd_field_updown.sv
// Two-digit BCD field counting modulo (MAX+1); nxt exposes the pre-register value.
module bcd_field_updown #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_digits,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [7:0] nxt,
  output logic       carry,
  output logic       borrow,
  output logic       is_zero
);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);

  logic at_max;

  assign is_zero = (tens == 4'd0) && (ones == 4'd0);
  assign at_max  = (tens == MAX_T) && (ones == MAX_O);
  assign carry   = inc & at_max;
  assign borrow  = dec & is_zero;

  always_comb begin
    nxt = {tens, ones};
    if (load) begin
      nxt = load_digits;
    end else if (inc) begin
      if (at_max)             nxt = 8'h00;
      else if (ones == 4'd9)  nxt = {tens + 4'd1, 4'd0};
      else                    nxt = {tens, ones + 4'd1};
    end else if (dec) begin
      if (is_zero)            nxt = {MAX_T, MAX_O};
      else if (ones == 4'd0)  nxt = {tens - 4'd1, 4'd9};
      else                    nxt = {tens, ones - 4'd1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {tens, ones} <= 8'h00;
    else     {tens, ones} <= nxt;
  end

endmodule

// File: rtl/time_core_updown.sv
// HH:MM:SS BCD up/down counter with adjust, validated preload and countdown expiry.
// Optional alarm compare enabled by defining ALARM_MATCH_EN.
module time_core_updown
  import time_core_updown_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int SEC_MAX  = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        run,
  input  logic        count_down,
  input  logic        adj_pulse,
  input  logic [1:0]  adj_field,
  input  logic        adj_dir,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        clr_expired,
`ifdef ALARM_MATCH_EN
  input  logic        alarm_set,
  input  logic [23:0] alarm_val,
  input  logic        alarm_arm,
  output logic        alarm_hit,
`endif
  output logic [3:0]  hr_tens,
  output logic [3:0]  hr_ones,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        wrap,
  output logic        expired,
  output logic        load_err
);
  logic load_ok, load_go, act_adj, act_tick, tick_up, tick_dn, all_zero;
  logic adj_sec, adj_min, adj_hr;
  logic sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic sec_carry, sec_borrow, sec_zero;
  logic min_carry, min_borrow, min_zero;
  logic hr_carry, hr_borrow, hr_zero;
  logic [7:0]  sec_nxt, min_nxt, hr_nxt;
  logic [23:0] nxt_all;

  // Priority: load > adjust > tick; losers are simply dropped
  assign load_ok  = time_ok(load_val, HOUR_MAX, SEC_MAX);
  assign load_go  = load & load_ok;
  assign act_adj  = !load && adj_pulse && (adj_field != FIELD_NONE);
  assign act_tick = !load && !act_adj && tick && run;
  assign all_zero = sec_zero & min_zero & hr_zero;
  assign tick_up  = act_tick & !count_down;
  assign tick_dn  = act_tick & count_down & !all_zero;

  assign adj_sec = act_adj && (adj_field == FIELD_SEC);
  assign adj_min = act_adj && (adj_field == FIELD_MIN);
  assign adj_hr  = act_adj && (adj_field == FIELD_HR);

  // Ripple only on ticks; adjust steps a single field in isolation
  assign sec_inc = tick_up | (adj_sec & !adj_dir);
  assign sec_dec = tick_dn | (adj_sec &  adj_dir);
  assign min_inc = (tick_up & sec_carry)  | (adj_min & !adj_dir);
  assign min_dec = (tick_dn & sec_borrow) | (adj_min &  adj_dir);
  assign hr_inc  = (tick_up & min_carry)  | (adj_hr  & !adj_dir);
  assign hr_dec  = (tick_dn & min_borrow) | (adj_hr  &  adj_dir);

  bcd_field_updown #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .dec(sec_dec), .load(load_go),
    .load_digits(load_val[SEC_LSB +: 8]), .tens(sec_tens), .ones(sec_ones),
    .nxt(sec_nxt), .carry(sec_carry), .borrow(sec_borrow), .is_zero(sec_zero));

  bcd_field_updown #(.MAX(SEC_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .dec(min_dec), .load(load_go),
    .load_digits(load_val[MIN_LSB +: 8]), .tens(min_tens), .ones(min_ones),
    .nxt(min_nxt), .carry(min_carry), .borrow(min_borrow), .is_zero(min_zero));

  bcd_field_updown #(.MAX(HOUR_MAX)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .dec(hr_dec), .load(load_go),
    .load_digits(load_val[HR_LSB +: 8]), .tens(hr_tens), .ones(hr_ones),
    .nxt(hr_nxt), .carry(hr_carry), .borrow(hr_borrow), .is_zero(hr_zero));

  assign nxt_all = {hr_nxt, min_nxt, sec_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tick_up & hr_carry;
      load_err <= load & !load_ok;
      if (load_go)                          expired <= 1'b0;
      else if (tick_dn && nxt_all == 24'h0) expired <= 1'b1;
      else if (clr_expired)                 expired <= 1'b0;
    end
  end

`ifdef ALARM_MATCH_EN
  logic [23:0] alarm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_reg <= 24'h0;
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= alarm_arm && (tick_up || tick_dn) && (nxt_all == alarm_reg);
      if (alarm_set && time_ok(alarm_val, HOUR_MAX, SEC_MAX)) alarm_reg <= alarm_val;
    end
  end
`endif

endmodule
